// File: rtl/cpu_pkg.sv
// Shared constants for the CPU performance monitor: FSM encoding, readout selects,
// and the default counter width.
package cpu_pkg;

    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam logic [1:0] SEL_CYCLE  = 2'd0;
    localparam logic [1:0] SEL_STALL  = 2'd1;
    localparam logic [1:0] SEL_FLUSH  = 2'd2;
    localparam logic [1:0] SEL_RETIRE = 2'd3;

endpackage

// File: rtl/perf_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter
    import cpu_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/perf_monitor.sv
// Pipeline performance monitor: counts cycles, load-use stalls, flushes and retires
// up to a cycle budget, with a coherent snapshot/readout port.
module perf_monitor
    import cpu_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int CYCLE_LIMIT = 30
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic             stall_i,
    input  logic             jump_i,
    input  logic             branch_i,
    input  logic             flush_i,
    input  logic             retire_i,
    input  logic [31:0]      pc_i,
    input  logic             snap_i,
    input  logic [1:0]       rd_sel_i,
    output logic [CNT_W-1:0] rdata_o,
    output logic             rvalid_o,
    output logic             halt_o,
    output logic [31:0]      halt_pc_o,
    output logic [1:0]       state_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt      [4];
    logic [CNT_W-1:0] shadow_q [4];
    logic [CNT_W-1:0] shadow_d [4];
    logic [CNT_W-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             halt_q, halt_d;
    logic [31:0]      halt_pc_q, halt_pc_d;
    logic [3:0]       inc;
    logic             run_en;
    logic             at_limit;

    // Counting needs both the RUN state and a live start; a dropped start is a pause.
    assign run_en   = (state_q == ST_RUN) && start_i;
    assign at_limit = (64'(cnt[0]) == 64'(CYCLE_LIMIT - 1));

    assign inc[0] = run_en;
    assign inc[1] = run_en && stall_i && !jump_i && !branch_i;
    assign inc[2] = run_en && flush_i;
    assign inc[3] = run_en && retire_i;

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (clear_i),
            .inc_i (inc[g]),
            .cnt_o (cnt[g])
        );
    end

    always_comb begin
        state_d   = state_q;
        halt_d    = halt_q;
        halt_pc_d = halt_pc_q;
        rvalid_d  = 1'b0;
        for (int i = 0; i < 4; i++) shadow_d[i] = shadow_q[i];

        if (clear_i) begin
            state_d   = start_i ? ST_RUN : ST_IDLE;
            halt_d    = 1'b0;
            halt_pc_d = '0;
            for (int i = 0; i < 4; i++) shadow_d[i] = '0;
        end else begin
            case (state_q)
                ST_IDLE: if (start_i) state_d = ST_RUN;
                ST_RUN: begin
                    if (!start_i) begin
                        state_d = ST_IDLE;
                    end else if (at_limit) begin
                        state_d   = ST_HALT;
                        halt_d    = 1'b1;
                        halt_pc_d = pc_i;
                    end
                end
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_IDLE;
            endcase
            // Shadows take pre-increment counts so the four values are coherent.
            if (snap_i) begin
                for (int i = 0; i < 4; i++) shadow_d[i] = cnt[i];
                rvalid_d = 1'b1;
            end
        end

        case (rd_sel_i)
            SEL_CYCLE: rdata_d = shadow_d[0];
            SEL_STALL: rdata_d = shadow_d[1];
            SEL_FLUSH: rdata_d = shadow_d[2];
            default:   rdata_d = shadow_d[3];
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            halt_q    <= 1'b0;
            halt_pc_q <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            for (int i = 0; i < 4; i++) shadow_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            halt_q    <= halt_d;
            halt_pc_q <= halt_pc_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            for (int i = 0; i < 4; i++) shadow_q[i] <= shadow_d[i];
        end
    end

    assign rdata_o   = rdata_q;
    assign rvalid_o  = rvalid_q;
    assign halt_o    = halt_q;
    assign halt_pc_o = halt_pc_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Scoreboard bench for perf_monitor: a 32-bit instance for the main scenarios and a
// 4-bit instance for saturation.
module tb_perf_monitor;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, clear, stall, jump, branch, flush, retire, snap;
    logic [31:0] pc;
    logic [1:0]  rd_sel;
    logic [31:0] rdata;
    logic        rvalid, halt;
    logic [31:0] halt_pc;
    logic [1:0]  state;

    logic        s_start, s_retire, s_snap;
    logic [1:0]  s_sel;
    logic [3:0]  s_rdata;
    logic        s_rvalid, s_halt;
    logic [31:0] s_halt_pc;
    logic [1:0]  s_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q [$];
    logic [3:0]  sexp_q [$];

    always #5 clk = ~clk;

    perf_monitor #(.CNT_W(32), .CYCLE_LIMIT(30)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
        .stall_i(stall), .jump_i(jump), .branch_i(branch), .flush_i(flush),
        .retire_i(retire), .pc_i(pc), .snap_i(snap), .rd_sel_i(rd_sel),
        .rdata_o(rdata), .rvalid_o(rvalid), .halt_o(halt),
        .halt_pc_o(halt_pc), .state_o(state)
    );

    perf_monitor #(.CNT_W(4), .CYCLE_LIMIT(30)) dut_s (
        .clk_i(clk), .rst_i(rst), .start_i(s_start), .clear_i(clear),
        .stall_i(stall), .jump_i(jump), .branch_i(branch), .flush_i(flush),
        .retire_i(s_retire), .pc_i(pc), .snap_i(s_snap), .rd_sel_i(s_sel),
        .rdata_o(s_rdata), .rvalid_o(s_rvalid), .halt_o(s_halt),
        .halt_pc_o(s_halt_pc), .state_o(s_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: pop one expected readout per rvalid pulse.
    always @(negedge clk) begin
        if (!rst && rvalid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL main_rvalid: unexpected pulse, rdata=%0h", rdata);
            end else begin
                check("main_rdata", 64'(rdata), 64'(exp_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && s_rvalid) begin
            if (sexp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL small_rvalid: unexpected pulse, rdata=%0h", s_rdata);
            end else begin
                check("small_rdata", 64'(s_rdata), 64'(sexp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; start = 0; clear = 0; stall = 0; jump = 0; branch = 0;
        flush = 0; retire = 0; snap = 0; pc = '0; rd_sel = 2'd0;
        s_start = 0; s_retire = 0; s_snap = 0; s_sel = 2'd0;

        // Reset values
        #12;
        check("rst_state", 64'(state), 64'(0));
        check("rst_halt", 64'(halt), 64'(0));
        check("rst_rvalid", 64'(rvalid), 64'(0));
        check("rst_rdata", 64'(rdata), 64'(0));
        check("rst_halt_pc", 64'(halt_pc), 64'(0));
        tick();
        rst = 1'b0;
        tick();

        // Budget of 30 RUN cycles from IDLE: one edge to enter RUN, then 30 counted
        start = 1'b1;
        n = 0;
        while (!halt && n < 60) begin tick(); n++; end
        check("t1_halt_edges", 64'(n), 64'(31));
        check("t1_halt", 64'(halt), 64'(1));
        check("t1_state", 64'(state), 64'(2));
        snap = 1'b1;
        for (int s = 0; s < 4; s++) begin
            rd_sel = 2'(s);
            exp_q.push_back((s == 0) ? 32'd30 : 32'd0);
            tick();
        end
        snap = 1'b0;
        tick(); tick();

        // Stall qualification and stall/flush overlap
        clear = 1'b1; tick(); clear = 1'b0;
        check("t2_state_after_clear", 64'(state), 64'(1));
        check("t2_halt_after_clear", 64'(halt), 64'(0));
        stall = 1; flush = 1;                          tick();
        stall = 1; jump = 1; flush = 0; retire = 1;    tick();
        stall = 1; jump = 0; flush = 1; retire = 0;    tick();
        stall = 0; flush = 1; retire = 1;              tick();
        flush = 1; retire = 0;                         tick();
        flush = 0; snap = 1;
        rd_sel = SEL_STALL;  exp_q.push_back(32'd2); tick();
        rd_sel = SEL_FLUSH;  exp_q.push_back(32'd4); tick();
        rd_sel = SEL_RETIRE; exp_q.push_back(32'd2); tick();
        rd_sel = SEL_CYCLE;  exp_q.push_back(32'd8); tick();
        snap = 0;
        tick();

        // Pause and resume; halt_pc capture
        clear = 1'b1; tick(); clear = 1'b0;
        repeat (10) tick();
        start = 1'b0; tick();
        check("t3_paused_state", 64'(state), 64'(0));
        snap = 1; rd_sel = SEL_CYCLE; exp_q.push_back(32'd10); tick();
        snap = 0;
        repeat (3) tick();
        start = 1'b1;
        n = 0;
        while (!halt && n < 40) begin pc = 32'(4 * n); tick(); n++; end
        check("t3_resume_edges", 64'(n), 64'(21));
        check("t3_halt_pc", 64'(halt_pc), 64'h50);
        check("t3_state", 64'(state), 64'(2));
        pc = 32'h1234;
        snap = 1; rd_sel = SEL_CYCLE; exp_q.push_back(32'd30); tick();
        snap = 0;
        tick();
        check("t3_halt_pc_held", 64'(halt_pc), 64'h50);

        // Saturation on the 4-bit instance
        s_start = 1; tick();
        s_retire = 1;
        repeat (14) tick();
        s_snap = 1; s_sel = SEL_RETIRE; sexp_q.push_back(4'd14); tick();
        s_snap = 0; tick(); tick();
        s_snap = 1; sexp_q.push_back(4'd15); tick();
        s_retire = 0; s_sel = SEL_CYCLE; sexp_q.push_back(4'd15); tick();
        s_snap = 0; tick(); tick();
        check("t4_small_halt", 64'(s_halt), 64'(0));
        check("t4_small_state", 64'(s_state), 64'(1));
        s_start = 0; tick();

        // Clear wins over snap on the same edge
        start = 0;
        clear = 1; snap = 1; rd_sel = SEL_CYCLE; tick();
        clear = 0;
        check("t5_rvalid_suppressed", 64'(rvalid), 64'(0));
        check("t5_state", 64'(state), 64'(0));
        check("t5_halt", 64'(halt), 64'(0));
        check("t5_halt_pc", 64'(halt_pc), 64'(0));
        rd_sel = SEL_CYCLE; exp_q.push_back(32'd0); tick();
        snap = 0;
        tick();

        // Async reset between edges
        start = 1; clear = 1; tick(); clear = 0;
        n = 0;
        while (!halt && n < 60) begin tick(); n++; end
        check("t6_halt_edges", 64'(n), 64'(30));
        snap = 1; rd_sel = SEL_CYCLE; tick();
        snap = 0;
        check("t6_rvalid_before_rst", 64'(rvalid), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("t6_rst_halt", 64'(halt), 64'(0));
        check("t6_rst_rvalid", 64'(rvalid), 64'(0));
        check("t6_rst_state", 64'(state), 64'(0));
        check("t6_rst_halt_pc", 64'(halt_pc), 64'(0));
        start = 0;
        tick();
        rst = 1'b0;
        tick(); tick();

        check("main_queue_drained", 64'(exp_q.size()), 64'(0));
        check("small_queue_drained", 64'(sexp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
